// File: rtl/cnn_state_mac_seq.sv
// cnn_state_mac_seq: sequential CNN state-update engine.
// Computes Xnew = sum(A*Y) + sum(B*U) + I over TAPS taps. Each RUN cycle
// evaluates one A*Y and one B*U product.
// Optional macro CNN_STATE_MAC_SAT_EN: when defined, out_data saturates when
// the result is out of range; when undefined, out_data wraps.
module cnn_state_mac_seq #(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned Y_W    = 17,
    parameter int unsigned TAPS   = 9,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned OUT_W  = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*DATA_W-1:0]   a_taps,
    input  logic [TAPS*DATA_W-1:0]   b_taps,
    input  logic [TAPS*DATA_W-1:0]   u_taps,
    input  logic [TAPS*Y_W-1:0]      y_taps,
    input  logic [DATA_W-1:0]        i_bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_ovf
);

    localparam int unsigned K_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned HI_W = ACC_W - OUT_W + 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state;
    logic [K_W-1:0]            k;
    logic signed [ACC_W-1:0]   acc;
    logic [TAPS*DATA_W-1:0]    a_r;
    logic [TAPS*DATA_W-1:0]    b_r;
    logic [TAPS*DATA_W-1:0]    u_r;
    logic [TAPS*Y_W-1:0]       y_r;

    logic signed [DATA_W-1:0]  a_sel;
    logic signed [DATA_W-1:0]  b_sel;
    logic signed [DATA_W-1:0]  u_sel;
    logic signed [Y_W-1:0]     y_sel;
    logic signed [ACC_W-1:0]   mac_sum_c;
    logic [HI_W-1:0]           res_hi_c;
    logic                      res_ovf_c;
    logic [OUT_W-1:0]          res_data_c;

    // Current-tap operand select, MAC step and width reduction of the new sum
    always_comb begin
        a_sel      = a_r[k*DATA_W +: DATA_W];
        b_sel      = b_r[k*DATA_W +: DATA_W];
        u_sel      = u_r[k*DATA_W +: DATA_W];
        y_sel      = y_r[k*Y_W +: Y_W];
        mac_sum_c  = acc + ACC_W'(a_sel) * ACC_W'(y_sel)
                         + ACC_W'(b_sel) * ACC_W'(u_sel);
        // In range exactly when all bits from the OUT_W sign bit up agree
        res_hi_c   = mac_sum_c[ACC_W-1:OUT_W-1];
        res_ovf_c  = !((&res_hi_c) || (~|res_hi_c));
`ifdef CNN_STATE_MAC_SAT_EN
        if (res_ovf_c) begin
            res_data_c = mac_sum_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            res_data_c = mac_sum_c[OUT_W-1:0];
        end
`else
        res_data_c = mac_sum_c[OUT_W-1:0];
`endif
    end

    // Control FSM with registered handshake outputs and operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            u_r       <= '0;
            y_r       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a_taps;
                        b_r      <= b_taps;
                        u_r      <= u_taps;
                        y_r      <= y_taps;
                        acc      <= ACC_W'(signed'(i_bias));
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= mac_sum_c;
                    if (k == K_LAST) begin
                        k         <= '0;
                        out_valid <= 1'b1;
                        out_data  <= res_data_c;
                        out_ovf   <= res_ovf_c;
                        state     <= DONE;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_state_mac_seq.sv
// Directed, table-driven bench for cnn_state_mac_seq (default parameters).
module tb_cnn_state_mac_seq;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned Y_W    = 17;
    localparam int unsigned TAPS   = 9;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned OUT_W  = 17;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [TAPS*DATA_W-1:0]  a_taps;
    logic [TAPS*DATA_W-1:0]  b_taps;
    logic [TAPS*DATA_W-1:0]  u_taps;
    logic [TAPS*Y_W-1:0]     y_taps;
    logic [DATA_W-1:0]       i_bias;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_data;
    logic                    out_ovf;

    int checks;
    int errors;

    cnn_state_mac_seq #(
        .DATA_W(DATA_W), .Y_W(Y_W), .TAPS(TAPS), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_taps(a_taps), .b_taps(b_taps), .u_taps(u_taps), .y_taps(y_taps),
        .i_bias(i_bias),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int u;
        int y;
        int i;
        bit ramp;
        int exp_data;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Uniform taps, or a ramp: A=k+1, Y=10(k+1), B=-(k+1), U=k
    task automatic load(input int a, input int b, input int u, input int y,
                        input int i, input bit ramp);
        for (int k = 0; k < int'(TAPS); k++) begin
            a_taps[k*DATA_W +: DATA_W] = DATA_W'(ramp ? k + 1 : a);
            b_taps[k*DATA_W +: DATA_W] = DATA_W'(ramp ? -(k + 1) : b);
            u_taps[k*DATA_W +: DATA_W] = DATA_W'(ramp ? k : u);
            y_taps[k*Y_W +: Y_W]       = Y_W'(ramp ? 10 * (k + 1) : y);
        end
        i_bias = DATA_W'(i);
    endtask

    // Wait in IDLE, accept at the next edge; returns at the negedge of cycle 1
    task automatic accept(input string name);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 0, 1);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_one(input string name, input vec_t v);
        int cyc;
        load(v.a, v.b, v.u, v.y, v.i, v.ramp);
        accept(name);
        wait_out(cyc);
        check({name, "_latency"}, cyc, TAPS + 1);
        check({name, "_data"}, longint'($signed(out_data)), v.exp_data);
        check({name, "_ovf"}, out_ovf, v.exp_ovf);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_drop"}, out_valid, 0);
        check({name, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int cyc;
        logic [OUT_W-1:0] held;
        bit seen;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        load(0, 0, 0, 0, 0, 1'b0);

        vecs[0] = '{1, 0, 0, 1, 0, 1'b0, 9, 1'b0};
        vecs[1] = '{-1, 2, 3, 100, 5, 1'b0, -841, 1'b0};
`ifdef CNN_STATE_MAC_SAT_EN
        vecs[2] = '{255, 0, 0, 65535, 0, 1'b0, 65535, 1'b1};
        vecs[3] = '{-256, 0, 0, 65535, 0, 1'b0, -65536, 1'b1};
        vecs[5] = '{1, 0, 0, 7281, 7, 1'b0, 65535, 1'b1};
        vecs[7] = '{-1, 0, 0, 7282, 1, 1'b0, -65536, 1'b1};
`else
        vecs[2] = '{255, 0, 0, 65535, 0, 1'b0, 63241, 1'b1};
        vecs[3] = '{-256, 0, 0, 65535, 0, 1'b0, 2304, 1'b1};
        vecs[5] = '{1, 0, 0, 7281, 7, 1'b0, -65536, 1'b1};
        vecs[7] = '{-1, 0, 0, 7282, 1, 1'b0, 65535, 1'b1};
`endif
        vecs[4] = '{1, 0, 0, 7281, 6, 1'b0, 65535, 1'b0};
        vecs[6] = '{-1, 0, 0, 7282, 2, 1'b0, -65536, 1'b0};
        vecs[8] = '{0, 0, 0, 0, -3, 1'b1, 2607, 1'b0};
        vecs[9] = '{0, 0, 0, 0, -256, 1'b0, -256, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", in_ready, 0);
        @(negedge clk);
        check("first_clk_ready", in_ready, 1);

        // Table
        foreach (vecs[n]) run_one($sformatf("vec%0d", n), vecs[n]);

        // Backpressure: result held, in_valid ignored
        load(-1, 2, 3, 100, 5, 1'b0);
        accept("bp");
        wait_out(cyc);
        check("bp_latency", cyc, TAPS + 1);
        held = out_data;
        load(1, 0, 0, 1, 0, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, held);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check("bp_held_value", longint'($signed(held)), -841);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_valid_drop", out_valid, 0);
        check("bp_idle_ready", in_ready, 1);
        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("idle_out_ready_valid", out_valid, 0);
        check("idle_out_ready_ready", in_ready, 1);

        // Flush in RUN cycle 4
        load(255, 0, 0, 65535, 0, 1'b0);
        accept("fl");
        repeat (3) @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_ready", in_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("fl_no_valid", seen, 0);
        run_one("fl_after", vecs[0]);

        // Async reset mid-RUN
        load(-1, 2, 3, 100, 5, 1'b0);
        accept("rr");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rr_in_ready", in_ready, 0);
        check("rr_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Async reset in DONE clears held result immediately
        load(-1, 2, 3, 100, 5, 1'b0);
        accept("rd");
        wait_out(cyc);
        check("rd_data_pre", longint'($signed(out_data)), -841);
        #2 rst_n = 1'b0;
        #1;
        check("rd_out_valid", out_valid, 0);
        check("rd_out_data", out_data, 0);
        check("rd_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rd_release_ready", in_ready, 1);

        // Back-to-back stream of three sets at the minimum interval
        run_one("s0", vecs[1]);
        run_one("s1", vecs[8]);
        run_one("s2", vecs[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
